// File: rtl/mutative_sram_1rw1r.sv
// 1RW + 1R behavioural SRAM with a post-reset clear sweep and write-first forwarding from port 0 to port 1.
// Define MUTATIVE_SRAM_OUT_REG_EN to add an output register stage on both ports (read latency 2 instead of 1).
module mutative_sram_1rw1r #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 7,
  parameter int WMASK_GRAN = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_WORD = '0
) (
  input  logic                             clk0,
  input  logic                             rst0,
  input  logic                             csb0,
  input  logic                             web0,
  input  logic [DATA_WIDTH/WMASK_GRAN-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]            addr0,
  input  logic [DATA_WIDTH-1:0]            din0,
  output logic [DATA_WIDTH-1:0]            dout0,
  output logic                             dvalid0,
  input  logic                             csb1,
  input  logic [ADDR_WIDTH-1:0]            addr1,
  output logic [DATA_WIDTH-1:0]            dout1,
  output logic                             dvalid1,
  output logic                             init_done
);

  localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;
  localparam int NUM_WMASKS = DATA_WIDTH / WMASK_GRAN;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

  logic                  w_ready;
  logic                  w_wr0;
  logic                  w_rd0;
  logic                  w_rd1;
  logic [DATA_WIDTH-1:0] w_rdata0;
  logic [DATA_WIDTH-1:0] w_rdata1;

  logic [DATA_WIDTH-1:0] r_dout0;
  logic [DATA_WIDTH-1:0] r_dout1;
  logic                  r_dvalid0;
  logic                  r_dvalid1;

  assign w_ready   = (r_state == ST_READY);
  assign w_wr0     = w_ready && !csb0 && !web0;
  assign w_rd0     = w_ready && !csb0 &&  web0;
  assign w_rd1     = w_ready && !csb1;
  assign init_done = w_ready;

  always_ff @(posedge clk0) begin
    if (rst0) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CLEAR) r_cnt <= r_cnt + ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: if (r_cnt == ADDR_WIDTH'(RAM_DEPTH - 1)) w_state_nxt = ST_READY;
      ST_READY: w_state_nxt = ST_READY;
      default:  w_state_nxt = ST_CLEAR;
    endcase
  end

  // NOTE: the array has no reset branch; the clear sweep initialises it, keeping it mappable to a RAM macro.
  always_ff @(posedge clk0) begin
    if (!rst0) begin
      if (!w_ready) begin
        r_mem[r_cnt] <= INIT_WORD;
      end else if (w_wr0) begin
        for (int i = 0; i < NUM_WMASKS; i++) begin
          if (wmask0[i]) r_mem[addr0][i*WMASK_GRAN +: WMASK_GRAN] <= din0[i*WMASK_GRAN +: WMASK_GRAN];
        end
      end
    end
  end

  // Port 1 sees lanes being written by port 0 on the same edge (write-first).
  always_comb begin
    w_rdata0 = r_mem[addr0];
    w_rdata1 = r_mem[addr1];
    for (int i = 0; i < NUM_WMASKS; i++) begin
      if (w_wr0 && (addr0 == addr1) && wmask0[i]) begin
        w_rdata1[i*WMASK_GRAN +: WMASK_GRAN] = din0[i*WMASK_GRAN +: WMASK_GRAN];
      end
    end
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      r_dout0   <= '0;
      r_dout1   <= '0;
      r_dvalid0 <= 1'b0;
      r_dvalid1 <= 1'b0;
    end else begin
      r_dvalid0 <= w_rd0;
      r_dvalid1 <= w_rd1;
      if (w_rd0) r_dout0 <= w_rdata0;
      if (w_rd1) r_dout1 <= w_rdata1;
    end
  end

`ifdef MUTATIVE_SRAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] r_dout0_q;
  logic [DATA_WIDTH-1:0] r_dout1_q;
  logic                  r_dvalid0_q;
  logic                  r_dvalid1_q;

  always_ff @(posedge clk0) begin
    if (rst0) begin
      r_dout0_q   <= '0;
      r_dout1_q   <= '0;
      r_dvalid0_q <= 1'b0;
      r_dvalid1_q <= 1'b0;
    end else begin
      r_dout0_q   <= r_dout0;
      r_dout1_q   <= r_dout1;
      r_dvalid0_q <= r_dvalid0;
      r_dvalid1_q <= r_dvalid1;
    end
  end

  assign dout0   = r_dout0_q;
  assign dout1   = r_dout1_q;
  assign dvalid0 = r_dvalid0_q;
  assign dvalid1 = r_dvalid1_q;
`else
  assign dout0   = r_dout0;
  assign dout1   = r_dout1;
  assign dvalid0 = r_dvalid0;
  assign dvalid1 = r_dvalid1;
`endif

endmodule
